// File: rtl/unary_mm_pkg.sv
// Shared types and sizing helpers for the unary matmul host sequencer.
package unary_mm_pkg;

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} seq_state_t;

  // Core reset is held low this many cycles so its counters clear before a run.
  localparam int START_CYC = 2;

  function automatic int elem_w(input int bw);
    return bw;
  endfunction

  function automatic int res_w(input int bw);
    return 2 * bw;
  endfunction

  // Width able to hold 0..n inclusive.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_index_ctr.sv
// Count-to-N index: advances on en, parks at N-1, returns to 0 only via clear.
module stream_index_ctr #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         done
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign done = en && (count == LAST);

  // Index register; clear is driven by the owner whenever it is not in its phase.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) count <= '0;
    else if (en && (count != LAST)) count <= count + 1'b1;
  end

endmodule

// File: rtl/unary_matmul_sequencer.sv
// Host front/back end for the unary systolic matmul core: serial operand load,
// core restart, result-ready edge detect, C snapshot and serial result drain.
module unary_matmul_sequencer
  import unary_mm_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int A_ROW     = 2,
  parameter int A_COL     = A_ROW,
  parameter int B_COL     = A_ROW
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BIT_WIDTH-1:0]               in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [2*BIT_WIDTH-1:0]             out_data,
  output logic                               busy,
  output logic                               mm_reset_n,
  output logic [A_ROW*A_COL*BIT_WIDTH-1:0]   mm_A,
  output logic [A_COL*B_COL*BIT_WIDTH-1:0]   mm_B,
  input  logic                               mm_output_ready,
  input  logic [A_ROW*B_COL*2*BIT_WIDTH-1:0] mm_C
);

  localparam int EW = elem_w(BIT_WIDTH);
  localparam int RW = res_w(BIT_WIDTH);
  localparam int NA = A_ROW * A_COL;
  localparam int NB = A_COL * B_COL;
  localparam int NC = A_ROW * B_COL;
  localparam int IW = idx_w(NA + NB);
  localparam int SW = idx_w(START_CYC);
  localparam int DW = idx_w(NC);

  seq_state_t state_q, state_d;

  // Flat row-major element order matches the packed [row][col] bus layout.
  logic [NA-1:0][EW-1:0] a_q;
  logic [NB-1:0][EW-1:0] b_q;
  logic [NC-1:0][RW-1:0] c_q;

  logic [IW-1:0] ld_idx;
  logic [DW-1:0] dr_idx;
  logic          ld_done, st_done, dr_done;
  logic          beat, ordy_q, ordy_rise;

  assign beat      = in_valid && in_ready;
  assign ordy_rise = (state_q == WAIT) && mm_output_ready && !ordy_q;
  assign mm_A      = a_q;
  assign mm_B      = b_q;

  stream_index_ctr #(.N(NA + NB), .W(IW)) u_ld_ctr (
    .clk(clk), .reset_n(reset_n), .en(beat), .clear(state_q != LOAD),
    .count(ld_idx), .done(ld_done));

  stream_index_ctr #(.N(START_CYC), .W(SW)) u_st_ctr (
    .clk(clk), .reset_n(reset_n), .en(state_q == START), .clear(state_q != START),
    .count(), .done(st_done));

  stream_index_ctr #(.N(NC), .W(DW)) u_dr_ctr (
    .clk(clk), .reset_n(reset_n), .en(out_valid && out_ready), .clear(state_q != DRAIN),
    .count(dr_idx), .done(dr_done));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // Next state and handshake/core-control outputs.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    mm_reset_n = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = reset_n;
        busy     = 1'b0;
        if (ld_done) state_d = START;
      end
      START: if (st_done) state_d = WAIT;
      WAIT: begin
        mm_reset_n = 1'b1;
        if (ordy_rise) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (dr_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Track the core level every cycle so a level already high when WAIT starts is no edge.
  always_ff @(posedge clk) begin
    if (!reset_n) ordy_q <= 1'b0;
    else          ordy_q <= mm_output_ready;
  end

  // Operand capture; only LOAD beats write, so the buses are frozen for the run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (beat) begin
      for (int i = 0; i < NA; i++) if (ld_idx == IW'(i)) a_q[i] <= in_data;
      for (int j = 0; j < NB; j++) if (ld_idx == IW'(NA + j)) b_q[j] <= in_data;
    end
  end

  // Result snapshot taken on the same edge the core completion is seen.
  always_ff @(posedge clk) begin
    if (!reset_n)       c_q <= '0;
    else if (ordy_rise) c_q <= mm_C;
  end

  // Drain mux; held at zero outside DRAIN.
  always_comb begin
    out_data = '0;
    if (state_q == DRAIN)
      for (int k = 0; k < NC; k++) if (dr_idx == DW'(k)) out_data = c_q[k];
  end

endmodule
